// File: rtl/wb_cmd_pkg.sv
// Shared definitions for the Wishbone command master: FSM state encoding,
// bus field widths and the width of the optional transfer timeout counter.
package wb_cmd_pkg;

  // Wishbone data, address and byte-select widths
  localparam int WB_DW = 32;
  localparam int WB_AW = 32;
  localparam int WB_SW = 4;

  // Width of the BUS-state watchdog counter (bounds TIMEOUT_CYCLES to 1..65535)
  localparam int TMO_CW = 16;

  // Transfer sequencing: accept command, run one classic cycle, hand back response
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/wb_cmd_master.sv
// Wishbone classic single-transfer initiator.
// A command taken on the valid/ready command port becomes exactly one
// classic cyc/stb cycle; the read data (or a timeout status) is returned on
// the valid/ready response port. One transfer is outstanding at a time.
// Optional feature macro: WB_CMD_MASTER_TIMEOUT_EN adds a watchdog that
// abandons a cycle after TIMEOUT_CYCLES strobe cycles without ack; without
// it the bus waits for ack forever and rsp_err_o is always 0.
module wb_cmd_master
  import wb_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  // command port
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic             cmd_we_i,
  input  logic [WB_AW-1:0] cmd_adr_i,
  input  logic [WB_DW-1:0] cmd_dat_i,
  input  logic [WB_SW-1:0] cmd_sel_i,
  // response port
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WB_DW-1:0] rsp_dat_o,
  output logic             rsp_err_o,
  // Wishbone initiator port
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [WB_SW-1:0] wbm_sel_o,
  output logic [WB_AW-1:0] wbm_adr_o,
  output logic [WB_DW-1:0] wbm_dat_o,
  input  logic             wbm_ack_i,
  input  logic [WB_DW-1:0] wbm_dat_i
);

  // An out-of-range timeout leaves this marker block in the elaborated
  // hierarchy; legal values (1..2^TMO_CW-1) elaborate nothing here.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (1 << TMO_CW) - 1) begin : g_timeout_out_of_range
  end

  state_t           state;
  logic             ready_reg;
  logic             cyc_reg;
  logic             we_reg;
  logic [WB_AW-1:0] adr_reg;
  logic [WB_DW-1:0] dat_reg;
  logic [WB_SW-1:0] sel_reg;
  logic             rsp_valid_reg;
  logic [WB_DW-1:0] rsp_dat_reg;
  logic             rsp_err_reg;
  logic             tmo_hit;

`ifdef WB_CMD_MASTER_TIMEOUT_EN
  // Terminal count: the strobe has then been high for TIMEOUT_CYCLES cycles
  localparam logic [TMO_CW-1:0] TMO_LAST = TMO_CW'(TIMEOUT_CYCLES - 1);

  logic [TMO_CW-1:0] tmo_cnt;

  // Count BUS cycles without ack; held at zero whenever the FSM is outside BUS
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      tmo_cnt <= '0;
    end else if (state != BUS) begin
      tmo_cnt <= '0;
    end else if (!wbm_ack_i) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign tmo_hit = (tmo_cnt == TMO_LAST);
`else
  assign tmo_hit = 1'b0;
`endif

  // Transfer sequencer: every port output is a register written here
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state         <= IDLE;
      ready_reg     <= 1'b0;
      cyc_reg       <= 1'b0;
      we_reg        <= 1'b0;
      adr_reg       <= '0;
      dat_reg       <= '0;
      sel_reg       <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_dat_reg   <= '0;
      rsp_err_reg   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ready_reg && cmd_valid_i) begin
            // Freeze the command so the bus sees it unchanged for the whole cycle
            we_reg    <= cmd_we_i;
            adr_reg   <= cmd_adr_i;
            dat_reg   <= cmd_dat_i;
            sel_reg   <= cmd_sel_i;
            cyc_reg   <= 1'b1;
            ready_reg <= 1'b0;
            state     <= BUS;
          end else begin
            // Also raises ready on the first edge after reset release
            ready_reg <= 1'b1;
          end
        end

        BUS: begin
          if (wbm_ack_i) begin
            // Ack wins over a timeout landing in the same cycle
            cyc_reg       <= 1'b0;
            rsp_valid_reg <= 1'b1;
            rsp_dat_reg   <= we_reg ? '0 : wbm_dat_i;
            rsp_err_reg   <= 1'b0;
            state         <= RESP;
          end else if (tmo_hit) begin
            cyc_reg       <= 1'b0;
            rsp_valid_reg <= 1'b1;
            rsp_dat_reg   <= '0;
            rsp_err_reg   <= 1'b1;
            state         <= RESP;
          end
        end

        RESP: begin
          if (rsp_ready_i) begin
            // No bypass: ready returns only in the cycle after the handshake
            rsp_valid_reg <= 1'b0;
            ready_reg     <= 1'b1;
            state         <= IDLE;
          end
        end

        default: begin
          cyc_reg       <= 1'b0;
          rsp_valid_reg <= 1'b0;
          ready_reg     <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready_o = ready_reg;
  assign rsp_valid_o = rsp_valid_reg;
  assign rsp_dat_o   = rsp_dat_reg;
  assign rsp_err_o   = rsp_err_reg;
  assign wbm_cyc_o   = cyc_reg;
  assign wbm_stb_o   = cyc_reg;
  assign wbm_we_o    = we_reg;
  assign wbm_adr_o   = adr_reg;
  assign wbm_dat_o   = dat_reg;
  assign wbm_sel_o   = sel_reg;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Testbench for wb_cmd_master: directed vector table, hold/stray-ack/reset
// sequences, optional timeout cases, and a back-to-back random run scored
// against a byte-lane memory reference model.
module tb_wb_cmd_master;

  localparam int TB_TIMEOUT = 8;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_ni = 1'b0;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic        cmd_we_i = 1'b0;
  logic [31:0] cmd_adr_i = '0;
  logic [31:0] cmd_dat_i = '0;
  logic [3:0]  cmd_sel_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b1;
  logic [31:0] rsp_dat_o;
  logic        rsp_err_o;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic        wbm_ack_i;
  logic [31:0] wbm_dat_i;

  wb_cmd_master #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_ni   (wb_rst_ni),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_we_i    (cmd_we_i),
    .cmd_adr_i   (cmd_adr_i),
    .cmd_dat_i   (cmd_dat_i),
    .cmd_sel_i   (cmd_sel_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_dat_o   (rsp_dat_o),
    .rsp_err_o   (rsp_err_o),
    .wbm_cyc_o   (wbm_cyc_o),
    .wbm_stb_o   (wbm_stb_o),
    .wbm_we_o    (wbm_we_o),
    .wbm_sel_o   (wbm_sel_o),
    .wbm_adr_o   (wbm_adr_o),
    .wbm_dat_o   (wbm_dat_o),
    .wbm_ack_i   (wbm_ack_i),
    .wbm_dat_i   (wbm_dat_i)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
  endtask

  // Byte-lane merge: lanes with sel=1 take the new data
  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++)
      if (sel[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  // ---------------- slave: memory with programmable wait states ----------------
  logic [31:0] slave_mem [logic [31:0]];
  int          slave_waits = 0;
  bit          slave_en = 1'b1;
  int          slave_cnt = 0;
  logic        slave_ack = 1'b0;
  logic        stray_ack = 1'b0;
  logic [31:0] slave_rdat = '0;

  assign wbm_ack_i = slave_ack | stray_ack;
  assign wbm_dat_i = slave_rdat;

  function automatic logic [31:0] slave_rd(input logic [31:0] a);
    return slave_mem.exists(a) ? slave_mem[a] : (a ^ 32'h5A5A_0000);
  endfunction

  always @(negedge wb_clk_i) begin
    if (wbm_cyc_o && wbm_stb_o) begin
      if (!slave_ack && slave_en && slave_cnt >= slave_waits) begin
        slave_ack <= 1'b1;
        if (wbm_we_o) slave_mem[wbm_adr_o] = merge(slave_rd(wbm_adr_o), wbm_dat_o, wbm_sel_o);
        else slave_rdat <= slave_rd(wbm_adr_o);
      end else begin
        slave_ack <= 1'b0;
      end
      slave_cnt <= slave_cnt + 1;
    end else begin
      slave_ack <= 1'b0;
      slave_cnt <= 0;
    end
  end

  // ---------------- reference model: word memory keyed by byte address ----------------
  logic [31:0] ref_mem [logic [31:0]];

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : (a ^ 32'h5A5A_0000);
  endfunction

  // ---------------- response monitor for the back-to-back run ----------------
  typedef struct { logic [31:0] dat; logic err; } rsp_t;
  rsp_t exp_q[$];
  bit   mon_en = 1'b0;
  int   cyc_n = 0;

  always @(posedge wb_clk_i) cyc_n <= cyc_n + 1;

  always @(negedge wb_clk_i) begin
    if (mon_en && rsp_valid_o && rsp_ready_i) begin
      if (exp_q.size() == 0) begin
        check("rand.unexpected_rsp", 32'd1, 32'd0);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        check("rand.rsp_dat", rsp_dat_o, e.dat);
        check("rand.rsp_err", {31'd0, rsp_err_o}, {31'd0, e.err});
        $display("rand rsp: dat=0x%08h err=%0d", rsp_dat_o, rsp_err_o);
      end
    end
  end

  // One complete transfer; starts and ends on a falling edge with rsp_ready_i=1
  task automatic run_cmd(input string nm, input logic we, input logic [31:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel, input int exp_stb,
                         input logic [31:0] exp_dat, input logic exp_err);
    int guard;
    int stb_cycles;
    bit stable;
    guard = 0;
    while (!cmd_ready_o && guard < 20) begin
      @(negedge wb_clk_i);
      guard++;
    end
    check({nm, ".cmd_ready"}, {31'd0, cmd_ready_o}, 32'd1);
    cmd_we_i = we; cmd_adr_i = adr; cmd_dat_i = dat; cmd_sel_i = sel;
    cmd_valid_i = 1'b1;
    @(negedge wb_clk_i);
    cmd_valid_i = 1'b0;
    check({nm, ".bus_start"}, {29'd0, wbm_cyc_o, wbm_stb_o, wbm_we_o}, {29'd0, 1'b1, 1'b1, we});
    check({nm, ".bus_adr"}, wbm_adr_o, adr);
    check({nm, ".bus_sel"}, {28'd0, wbm_sel_o}, {28'd0, sel});
    if (we) check({nm, ".bus_dat"}, wbm_dat_o, dat);
    stb_cycles = 0;
    stable = 1'b1;
    while (wbm_cyc_o && stb_cycles < 300) begin
      stb_cycles++;
      if (wbm_adr_o !== adr || wbm_sel_o !== sel || wbm_we_o !== we || !wbm_stb_o) stable = 1'b0;
      @(negedge wb_clk_i);
    end
    check({nm, ".stb_cycles"}, stb_cycles, exp_stb);
    check({nm, ".bus_stable"}, {31'd0, stable}, 32'd1);
    check({nm, ".rsp_valid"}, {31'd0, rsp_valid_o}, 32'd1);
    check({nm, ".rsp_dat"}, rsp_dat_o, exp_dat);
    check({nm, ".rsp_err"}, {31'd0, rsp_err_o}, {31'd0, exp_err});
    $display("%s: we=%0d adr=0x%08h stb=%0d rsp_dat=0x%08h err=%0d",
             nm, we, adr, stb_cycles, rsp_dat_o, rsp_err_o);
    @(negedge wb_clk_i);
    check({nm, ".ready_after"}, {30'd0, cmd_ready_o, rsp_valid_o}, 32'd2);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          waits;
    int          exp_stb;
    logic [31:0] exp_dat;
    logic        exp_err;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int prev_acc;
    int guard;

    vecs[0] = '{1'b1, 32'h3000_0004, 32'hA5A5_0001, 4'hF, 0, 1, 32'h0, 1'b0};
    vecs[1] = '{1'b0, 32'h3000_0000, 32'h0,         4'hF, 3, 4, 32'hDEAD_BEEF, 1'b0};
    vecs[2] = '{1'b0, 32'h3000_0004, 32'h0,         4'hF, 1, 2, 32'hA5A5_0001, 1'b0};
    vecs[3] = '{1'b1, 32'h3000_0004, 32'h1122_3344, 4'h3, 2, 3, 32'h0, 1'b0};
    vecs[4] = '{1'b0, 32'h3000_0004, 32'h0,         4'hF, 0, 1, 32'hA5A5_3344, 1'b0};
    vecs[5] = '{1'b1, 32'h3000_0008, 32'hCAFE_F00D, 4'hC, 0, 1, 32'h0, 1'b0};
    vecs[6] = '{1'b0, 32'h3000_0008, 32'h0,         4'hF, 0, 1, 32'hCAFE_0008, 1'b0};

    slave_mem[32'h3000_0000] = 32'hDEAD_BEEF;
    ref_mem[32'h3000_0000]   = 32'hDEAD_BEEF;

    // Reset: every output low while held
    repeat (3) @(negedge wb_clk_i);
    check("reset.ctrl", {25'd0, cmd_ready_o, rsp_valid_o, rsp_err_o, wbm_cyc_o, wbm_stb_o,
                         wbm_we_o, |wbm_sel_o}, 32'd0);
    check("reset.data", wbm_adr_o | wbm_dat_o | rsp_dat_o, 32'd0);
    wb_rst_ni = 1'b1;
    @(negedge wb_clk_i);
    check("reset.ready_release", {31'd0, cmd_ready_o}, 32'd1);

    // Ack outside BUS must be ignored
    stray_ack = 1'b1;
    repeat (2) @(negedge wb_clk_i);
    stray_ack = 1'b0;
    check("stray_ack.idle", {30'd0, wbm_cyc_o, rsp_valid_o}, 32'd0);

    // Directed vector table
    for (int i = 0; i < 7; i++) begin
      slave_waits = vecs[i].waits;
      run_cmd($sformatf("vec%0d", i), vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel,
              vecs[i].exp_stb, vecs[i].exp_dat, vecs[i].exp_err);
      if (vecs[i].we) ref_mem[vecs[i].adr] = merge(ref_rd(vecs[i].adr), vecs[i].dat, vecs[i].sel);
    end
    slave_waits = 0;

    // Response back-pressure: data held, no new command taken
    rsp_ready_i = 1'b0;
    cmd_we_i = 1'b0; cmd_adr_i = 32'h3000_0004; cmd_sel_i = 4'hF;
    cmd_valid_i = 1'b1;
    @(negedge wb_clk_i);
    cmd_valid_i = 1'b0;
    guard = 0;
    while (wbm_cyc_o && guard < 50) begin
      @(negedge wb_clk_i);
      guard++;
    end
    for (int c = 0; c < 10; c++) begin
      cmd_we_i = 1'b1; cmd_adr_i = 32'h3000_0020; cmd_dat_i = 32'hBAD0_BAD0;
      cmd_valid_i = 1'b1;
      check("hold.rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
      check("hold.rsp_dat", rsp_dat_o, 32'hA5A5_3344);
      check("hold.no_accept", {30'd0, cmd_ready_o, wbm_cyc_o}, 32'd0);
      @(negedge wb_clk_i);
    end
    $display("hold: rsp held 10 cycles dat=0x%08h", rsp_dat_o);
    cmd_valid_i = 1'b0;
    rsp_ready_i = 1'b1;
    @(negedge wb_clk_i);
    check("hold.release", {30'd0, cmd_ready_o, rsp_valid_o}, 32'd2);

`ifdef WB_CMD_MASTER_TIMEOUT_EN
    // Watchdog: no ack -> TB_TIMEOUT strobe cycles then error
    slave_en = 1'b0;
    run_cmd("tmo.noack", 1'b0, 32'h3000_0000, 32'h0, 4'hF, TB_TIMEOUT, 32'h0, 1'b1);
    slave_en = 1'b1;
    // Ack in the last allowed cycle completes normally
    slave_waits = TB_TIMEOUT - 1;
    run_cmd("tmo.lastack", 1'b0, 32'h3000_0000, 32'h0, 4'hF, TB_TIMEOUT, 32'hDEAD_BEEF, 1'b0);
    // Ack one cycle too late is never seen
    slave_waits = TB_TIMEOUT;
    run_cmd("tmo.lateack", 1'b0, 32'h3000_0000, 32'h0, 4'hF, TB_TIMEOUT, 32'h0, 1'b1);
    slave_waits = 0;
`endif

    // Asynchronous reset in the middle of a bus cycle
    slave_en = 1'b0;
    cmd_we_i = 1'b0; cmd_adr_i = 32'h3000_0000; cmd_sel_i = 4'hF;
    cmd_valid_i = 1'b1;
    @(negedge wb_clk_i);
    cmd_valid_i = 1'b0;
    @(negedge wb_clk_i);
    check("rst_mid.in_bus", {30'd0, wbm_cyc_o, wbm_stb_o}, 32'd3);
    #2 wb_rst_ni = 1'b0;
    #1;
    check("rst_mid.async_drop", {28'd0, wbm_cyc_o, wbm_stb_o, rsp_valid_o, cmd_ready_o}, 32'd0);
    @(negedge wb_clk_i);
    wb_rst_ni = 1'b1;
    slave_en = 1'b1;
    @(negedge wb_clk_i);
    check("rst_mid.ready", {30'd0, cmd_ready_o, wbm_cyc_o}, 32'd2);
    $display("rst_mid: cyc dropped asynchronously, ready restored");
    run_cmd("rst_mid.write", 1'b1, 32'h3000_0010, 32'h1234_5678, 4'hF, 1, 32'h0, 1'b0);
    ref_mem[32'h3000_0010] = merge(ref_rd(32'h3000_0010), 32'h1234_5678, 4'hF);
    run_cmd("rst_mid.readback", 1'b0, 32'h3000_0010, 32'h0, 4'hF, 1, 32'h1234_5678, 1'b0);

    // Back-to-back random traffic: accept, bus, response -> next accept 3 edges later
    mon_en = 1'b1;
    prev_acc = 0;
    for (int i = 0; i < 16; i++) begin
      rsp_t e;
      cmd_we_i  = 1'($urandom_range(0, 1));
      cmd_adr_i = 32'h3000_0000 + 32'($urandom_range(0, 7) * 4);
      cmd_dat_i = $urandom;
      cmd_sel_i = 4'($urandom_range(1, 15));
      cmd_valid_i = 1'b1;
      guard = 0;
      while (!cmd_ready_o && guard < 20) begin
        @(negedge wb_clk_i);
        guard++;
      end
      if (guard >= 20) check("rand.accept_timeout", 32'd1, 32'd0);
      if (cmd_we_i) begin
        ref_mem[cmd_adr_i] = merge(ref_rd(cmd_adr_i), cmd_dat_i, cmd_sel_i);
        e.dat = 32'h0;
      end else begin
        e.dat = ref_rd(cmd_adr_i);
      end
      e.err = 1'b0;
      exp_q.push_back(e);
      $display("rand cmd %0d: we=%0d adr=0x%08h dat=0x%08h sel=0x%0h",
               i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i);
      if (i > 0) check("rand.spacing", cyc_n - prev_acc, 32'd3);
      prev_acc = cyc_n;
      @(negedge wb_clk_i);
    end
    cmd_valid_i = 1'b0;
    repeat (6) @(negedge wb_clk_i);
    check("rand.all_responded", exp_q.size(), 32'd0);
    mon_en = 1'b0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before 200000ns");
    $fatal(1);
  end

endmodule
